// File: rtl/counter_countdown_pkg.sv
// counter_countdown_pkg: shared control bundle, counter state encoding and width helper
package counter_countdown_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
  typedef struct packed {
    logic clk;
    logic rst;
  } data_control_t;
  function automatic logic data_control_clock(data_control_t c);
    return c.clk;
  endfunction
  function automatic logic data_control_reset(data_control_t c);
    return c.rst;
  endfunction
  // Bits needed for values 0..n-1, never less than one
  function automatic int util_math_log2(int n);
    int r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/counter_countdown_delay_arr.sv
// counter_countdown_delay_arr: D-stage clearable register delay line (D=0 is a wire)
module counter_countdown_delay_arr #(
  parameter int W = 1,
  parameter int D = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  if (D == 0) begin : g_pass
    assign dout = din;
  end else begin : g_pipe
    logic [D*W-1:0] sr;
    always_ff @(posedge clk) sr <= rst ? '0 : (D*W)'({sr, din});
    assign dout = sr[D*W-1 -: W];
  end
endmodule

// File: rtl/counter_countdown.sv
// counter_countdown: loadable one-shot/periodic down-counter with terminal tick and delayed outputs
module counter_countdown
  import counter_countdown_pkg::*;
#(
  parameter int MAX   = 16,
  parameter int WIDTH = util_math_log2(MAX),
  parameter int DELAY = 0
) (
  input  data_control_t    ctrl,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             enable,
  input  logic             periodic,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             expired,
  output logic             tick
);
  localparam logic [WIDTH-1:0] top_val = WIDTH'(MAX - 1);
  logic clk, rst;
  state_t state, state_n;
  logic [WIDTH-1:0] count, count_n, reload, reload_n, d_c;
  logic tk, tk_n;
  assign clk = data_control_clock(ctrl);
  assign rst = data_control_reset(ctrl);
  assign d_c = ({1'b0, d} >= (WIDTH+1)'(MAX)) ? top_val : d;
  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload;
    tk_n     = 1'b0;
    if (load) begin
      count_n  = d_c;
      reload_n = d_c;
    end else if (stop && state == RUN) begin
      state_n = IDLE;
    end else if (start) begin
      count_n = reload;
      state_n = RUN;
    end else if (state == RUN && enable) begin
      if (count != '0) begin
        count_n = count - 1'b1;
      end else begin
        tk_n    = 1'b1;
        count_n = periodic ? reload : '0;
        state_n = periodic ? RUN : DONE;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tk     <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      reload <= reload_n;
      tk     <= tk_n;
    end
  end
  counter_countdown_delay_arr #(.W(WIDTH + 3), .D(DELAY)) u_delay (
    .clk  (clk),
    .rst  (rst),
    .din  ({count, state == RUN, state == DONE, tk}),
    .dout ({q, busy, expired, tick})
  );
endmodule
